// File: rtl/writeback_ext.sv
// rtl/writeback_ext.sv - parametrised writeback stage with load alignment, variable-latency response wait and retire counter
module writeback_ext #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64,
  localparam int OFS_W = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_m,
  input  logic              rd_write_m,
  input  logic [1:0]        rd_write_src_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [XLEN-1:0]   pc_m,
  input  logic [XLEN-1:0]   alu_res_m,
  input  logic [XLEN-1:0]   csr_data_m,
  input  logic [1:0]        mem_size_m,
  input  logic              mem_unsigned_m,
  input  logic [OFS_W-1:0]  mem_ofs_m,
  input  logic              flush_w,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              stall_w,
  output logic              rd_write_w,
  output logic [REG_AW-1:0] rd_w,
  output logic [XLEN-1:0]   rd_data_w,
  output logic              load_err_w,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [1:0] RDSRC_PC  = 2'd0;
  localparam logic [1:0] RDSRC_ALU = 2'd1;
  localparam logic [1:0] RDSRC_MEM = 2'd2;
  localparam logic [1:0] RDSRC_CSR = 2'd3;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic              v_w, rd_write_r, uns_r;
  logic [1:0]        src_r, size_r;
  logic [REG_AW-1:0] rd_r;
  logic [XLEN-1:0]   pc_r, alu_r, csr_r;
  logic [OFS_W-1:0]  ofs_r;
  logic [CNT_W-1:0]  retire_r;

  logic              load_w, draining, commit, fault, stall, kill_w;
  logic [XLEN-1:0]   sh, mask, ld, sel;
  logic [1:0]        eff_size;
  logic [6:0]        nbits;
  logic              sbit;

  always_comb begin
    load_w   = v_w & (src_r == RDSRC_MEM);
    draining = (state == ST_DRAIN);
    commit   = v_w & ~draining & (~load_w | (mem_rsp_valid & ~mem_rsp_err));
    fault    = load_w & ~draining & mem_rsp_valid & mem_rsp_err;
    stall    = (load_w & ~mem_rsp_valid) | draining;
  end

  // A flush while the load is still outstanding drops it; its response must then be drained.
  always_comb begin
    state_nxt = state;
    kill_w    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (load_w & ~mem_rsp_valid) begin
          if (flush_w) begin
            state_nxt = ST_DRAIN;
            kill_w    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = ST_RUN;
        end else if (flush_w) begin
          state_nxt = ST_DRAIN;
          kill_w    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Load alignment: the mask's top bit locates the sign bit for the selected access size.
  always_comb begin
    sh       = mem_rsp_data >> {ofs_r, 3'b000};
    eff_size = (XLEN == 32 && size_r == 2'd3) ? 2'd2 : size_r;
    nbits    = 7'd8 << eff_size;
    mask     = {XLEN{1'b1}} >> (7'(XLEN) - nbits);
    sbit     = |(sh & (mask ^ (mask >> 1)));
    ld       = (sh & mask) | ((sbit & ~uns_r) ? ~mask : '0);
  end

  always_comb begin
    sel = '0;
    unique case (src_r)
      RDSRC_PC:  sel = pc_r + XLEN'(4);
      RDSRC_ALU: sel = alu_r;
      RDSRC_MEM: sel = ld;
      RDSRC_CSR: sel = csr_r;
      default:   sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      v_w        <= 1'b0;
      rd_write_r <= 1'b0;
      src_r      <= '0;
      rd_r       <= '0;
      pc_r       <= '0;
      alu_r      <= '0;
      csr_r      <= '0;
      size_r     <= '0;
      uns_r      <= 1'b0;
      ofs_r      <= '0;
      retire_r   <= '0;
    end else begin
      state <= state_nxt;
      if (commit) retire_r <= retire_r + 1'b1;
      if (!stall) begin
        v_w        <= valid_m & ~flush_w;
        rd_write_r <= rd_write_m;
        src_r      <= rd_write_src_m;
        rd_r       <= rd_m;
        pc_r       <= pc_m;
        alu_r      <= alu_res_m;
        csr_r      <= csr_data_m;
        size_r     <= mem_size_m;
        uns_r      <= mem_unsigned_m;
        ofs_r      <= mem_ofs_m;
      end else if (kill_w) begin
        v_w <= 1'b0;
      end
    end
  end

  assign stall_w    = stall;
  assign rd_write_w = commit & rd_write_r & (rd_r != '0);
  assign rd_w       = rd_r;
  assign rd_data_w  = rd_write_w ? sel : '0;
  assign load_err_w = fault;
  assign retire_cnt = retire_r;

endmodule

// File: tb/tb_writeback_ext.sv
// tb/tb_writeback_ext.sv - self-checking bench for writeback_ext (XLEN=32)
module tb_writeback_ext;
  localparam logic [1:0] PC = 2'd0, ALU = 2'd1, MEM = 2'd2, CSR = 2'd3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid_m, rd_write_m, mem_unsigned_m, flush_w, mem_rsp_valid, mem_rsp_err;
  logic [1:0]  rd_write_src_m, mem_size_m, mem_ofs_m;
  logic [4:0]  rd_m, rd_w;
  logic [31:0] pc_m, alu_res_m, csr_data_m, mem_rsp_data, rd_data_w;
  logic        stall_w, rd_write_w, load_err_w;
  logic [63:0] retire_cnt;

  writeback_ext #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .rd_write_m(rd_write_m),
    .rd_write_src_m(rd_write_src_m), .rd_m(rd_m), .pc_m(pc_m), .alu_res_m(alu_res_m),
    .csr_data_m(csr_data_m), .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
    .mem_ofs_m(mem_ofs_m), .flush_w(flush_w), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err), .stall_w(stall_w),
    .rd_write_w(rd_write_w), .rd_w(rd_w), .rd_data_w(rd_data_w),
    .load_err_w(load_err_w), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, we, uns, err, exp_we;
    logic [1:0]  src, size, ofs;
    logic [4:0]  rd;
    logic [31:0] pc, alu, csr, rsp, exp_data;
  } vec_t;

  int          errors = 0, checks = 0;
  logic [63:0] exp_cnt = 64'd0;
  vec_t        vt[16];
  vec_t        sb[$];
  vec_t        e;

  function automatic vec_t mk(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] opnd,
                              input logic [1:0] size, input logic uns, input logic [1:0] ofs,
                              input logic [31:0] rsp, input logic err,
                              input logic exp_we, input logic [31:0] exp_data);
    vec_t v;
    v.valid = 1'b1; v.we = 1'b1; v.src = src; v.rd = rd;
    v.pc  = (src == PC)  ? opnd : 32'h0000_0F00;
    v.alu = (src == ALU) ? opnd : ~opnd;
    v.csr = (src == CSR) ? opnd : 32'h5A5A_5A5A;
    v.size = size; v.uns = uns; v.ofs = ofs; v.rsp = rsp; v.err = err;
    v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic st, input logic le);
    chk({tag, ".rd_write_w"}, rd_write_w, we);
    if (we) chk({tag, ".rd_w"}, rd_w, rd);
    chk({tag, ".rd_data_w"}, rd_data_w, d);
    chk({tag, ".stall_w"}, stall_w, st);
    chk({tag, ".load_err_w"}, load_err_w, le);
    chk({tag, ".retire_cnt"}, retire_cnt, exp_cnt);
  endtask

  task automatic drive_m(input vec_t v);
    valid_m = v.valid; rd_write_m = v.we; rd_write_src_m = v.src; rd_m = v.rd;
    pc_m = v.pc; alu_res_m = v.alu; csr_data_m = v.csr;
    mem_size_m = v.size; mem_unsigned_m = v.uns; mem_ofs_m = v.ofs;
  endtask

  task automatic idle_m();
    valid_m = 1'b0; rd_write_m = 1'b0; rd_write_src_m = ALU; rd_m = 5'd0;
    pc_m = '0; alu_res_m = '0; csr_data_m = '0;
    mem_size_m = '0; mem_unsigned_m = 1'b0; mem_ofs_m = '0;
  endtask

  task automatic rsp(input logic v, input logic [31:0] d, input logic err);
    mem_rsp_valid = v; mem_rsp_data = d; mem_rsp_err = err;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(ALU, 5'd5,  32'h0000_1234, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_1234);
    vt[1]  = mk(MEM, 5'd6,  32'h0,         2'd0, 1'b0, 2'd3, 32'h80FF_0000, 1'b0, 1'b1, 32'hFFFF_FF80);
    vt[2]  = mk(MEM, 5'd7,  32'h0,         2'd1, 1'b1, 2'd2, 32'h8001_ABCD, 1'b0, 1'b1, 32'h0000_8001);
    vt[3]  = mk(PC,  5'd1,  32'h0000_0100, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0104);
    vt[4]  = mk(ALU, 5'd0,  32'h0000_0055, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    vt[5]  = mk(CSR, 5'd9,  32'hCAFE_0001, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001);
    vt[6]  = mk(MEM, 5'd10, 32'h0,         2'd2, 1'b0, 2'd0, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678);
    vt[7]  = mk(MEM, 5'd11, 32'h0,         2'd1, 1'b0, 2'd0, 32'h0000_8123, 1'b0, 1'b1, 32'hFFFF_8123);
    vt[8]  = mk(MEM, 5'd12, 32'h0,         2'd0, 1'b1, 2'd1, 32'h0000_9A00, 1'b0, 1'b1, 32'h0000_009A);
    vt[9]  = mk(MEM, 5'd13, 32'h0,         2'd2, 1'b0, 2'd0, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
    vt[10] = mk(ALU, 5'd14, 32'h0000_0077, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    vt[10].valid = 1'b0;
    vt[11] = mk(ALU, 5'd14, 32'h0000_0088, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    vt[11].we = 1'b0;
    vt[12] = mk(MEM, 5'd15, 32'h0,         2'd3, 1'b0, 2'd0, 32'h8765_4321, 1'b0, 1'b1, 32'h8765_4321);
    vt[13] = mk(PC,  5'd16, 32'hFFFF_FFFC, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0000);
    vt[14] = mk(MEM, 5'd17, 32'h0,         2'd0, 1'b0, 2'd2, 32'h007F_0000, 1'b0, 1'b1, 32'h0000_007F);
    vt[15] = mk(MEM, 5'd18, 32'h0,         2'd2, 1'b0, 2'd2, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h0000_AABB);

    idle_m(); flush_w = 1'b0; rsp(1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_w("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("reset.rd_w", rd_w, 5'd0);
    rst_n = 1'b1;

    // Pipelined table: M carries vt[i] while W sees the response for the scoreboard head.
    for (int i = 0; i <= 16; i++) begin
      next_cycle();
      if (i < 16) drive_m(vt[i]); else idle_m();
      if (sb.size() > 0 && sb[0].valid && sb[0].src == MEM) rsp(1'b1, sb[0].rsp, sb[0].err);
      else rsp(1'b0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_w($sformatf("vec%0d", i - 1), e.exp_we, e.rd, e.exp_data, 1'b0,
              e.valid & (e.src == MEM) & e.err);
        if (e.valid && !(e.src == MEM && e.err)) exp_cnt++;
      end
      if (i < 16) sb.push_back(vt[i]);
    end

    // Delayed load: three stall cycles with M held, then write, then the held instruction.
    next_cycle(); drive_m(mk(MEM, 5'd3, 32'h0, 2'd2, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    rsp(1'b0, 32'h0, 1'b0);
    @(negedge clk); chk_w("dly.idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      next_cycle(); drive_m(mk(ALU, 5'd4, 32'h0000_0077, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
      @(negedge clk); chk_w($sformatf("dly.wait%0d", c), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    end
    next_cycle(); rsp(1'b1, 32'h0000_A5A5, 1'b0);
    @(negedge clk); chk_w("dly.rsp", 1'b1, 5'd3, 32'h0000_A5A5, 1'b0, 1'b0); exp_cnt++;
    next_cycle(); idle_m(); rsp(1'b0, 32'h0, 1'b0);
    @(negedge clk); chk_w("dly.next", 1'b1, 5'd4, 32'h0000_0077, 1'b0, 1'b0); exp_cnt++;

    // Flush during WAIT: drain the orphan response with no write or error.
    next_cycle(); drive_m(mk(MEM, 5'd8, 32'h0, 2'd2, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    @(negedge clk);
    next_cycle(); idle_m();
    @(negedge clk); chk_w("fl.run", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); flush_w = 1'b1;
    @(negedge clk); chk_w("fl.wait", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); flush_w = 1'b0;
    @(negedge clk); chk_w("fl.drain", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); rsp(1'b1, 32'h0000_DEAD, 1'b0);
    @(negedge clk); chk_w("fl.orphan", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); rsp(1'b0, 32'h0, 1'b0);
    drive_m(mk(ALU, 5'd2, 32'h0000_0042, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    @(negedge clk); chk_w("fl.back", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    next_cycle(); idle_m();
    @(negedge clk); chk_w("fl.after", 1'b1, 5'd2, 32'h0000_0042, 1'b0, 1'b0); exp_cnt++;

    // Flush never kills the committing W instruction, only the incoming one.
    next_cycle(); drive_m(mk(ALU, 5'd17, 32'h0000_0011, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    @(negedge clk);
    next_cycle(); drive_m(mk(ALU, 5'd18, 32'h0000_0022, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    flush_w = 1'b1;
    @(negedge clk); chk_w("fc.commit", 1'b1, 5'd17, 32'h0000_0011, 1'b0, 1'b0); exp_cnt++;
    next_cycle(); idle_m(); flush_w = 1'b0;
    @(negedge clk); chk_w("fc.killed", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Reset mid-WAIT, then stray responses must be ignored.
    next_cycle(); drive_m(mk(MEM, 5'd20, 32'h0, 2'd2, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    @(negedge clk);
    next_cycle(); idle_m();
    @(negedge clk); chk_w("rw.run", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); rst_n = 1'b0;
    @(negedge clk); chk_w("rw.wait", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    next_cycle(); rst_n = 1'b1; exp_cnt = 64'd0;
    @(negedge clk); chk_w("rw.reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("rw.reset.rd_w", rd_w, 5'd0);
    next_cycle(); rsp(1'b1, 32'h0000_BEEF, 1'b0);
    @(negedge clk); chk_w("rw.stray", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    next_cycle(); rsp(1'b1, 32'h0000_BEEF, 1'b1);
    @(negedge clk); chk_w("rw.stray_err", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    next_cycle(); rsp(1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
